shift_add_mult_seq: RTL and testbench

- Sequential shift-and-add unsigned multiplier.
- Drives a one-hot shift-select to a combinational one-hot shifter stage and accumulates the shifted partial products, one multiplier bit per cycle.
- Sits directly upstream of the one-hot shifter: it generates the data/one-hot-select pairs that stage consumes, and widens the result to a full 2*WIDTH-bit product.
- Start/busy/done handshake toward the datapath controller.

---
 rtl/shift_add_mult_seq_pkg.sv | 34 +++
 rtl/shift_add_mult_seq_onehot_shift.sv | 29 ++
 rtl/shift_add_mult_seq.sv | 110 +++++++++++
 tb/tb_shift_add_mult_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mult_seq_pkg
//  Description : Shared types and helpers for the sequential shift-and-add
//                multiplier and its one-hot shifter stage.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_add_mult_seq_pkg;

    // Default operand width in bits. The product is twice this width.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states. The encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Converts a one-hot vector to the index of its set bit. An all-zero
    // input yields 0; shifting by zero keeps the result harmless.
    function automatic int onehot_to_index(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_mult_seq_onehot_shift.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_shift
//  Description : Combinational shifter. Moves data left by the position
//                marked in a one-hot select and zero-extends to 2*WIDTH bits.
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_shift
    import shift_add_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [WIDTH-1:0]   sel,
    output logic [2*WIDTH-1:0] shifted
);

    logic [2*WIDTH-1:0] w_data_ext;
    int                 w_idx;

    // Widen first so no bits are lost when shifting up to WIDTH-1 places.
    always_comb begin
        w_data_ext = {{WIDTH{1'b0}}, data};
        w_idx      = onehot_to_index(32'(sel));
        shifted    = w_data_ext << w_idx;
    end

endmodule
`default_nettype wire

// File: rtl/shift_add_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mult_seq
//  Description : Sequential unsigned shift-and-add multiplier. Examines one
//                multiplier bit per cycle via a rotating one-hot select and
//                accumulates shifted partial products into a 2*WIDTH result.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_add_mult_seq
    import shift_add_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sel;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_p;
    logic               r_busy;
    logic               r_done;

    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_acc_next;

    // Partial product: captured multiplicand moved to the selected bit weight.
    onehot_shift #(
        .WIDTH (WIDTH)
    ) u_onehot_shift (
        .data    (r_a),
        .sel     (r_sel),
        .shifted (w_pp)
    );

    // Add the partial product only when the selected multiplier bit is set.
    always_comb begin
        w_acc_next = r_acc;
        if (|(r_b & r_sel)) begin
            w_acc_next = r_acc + w_pp;
        end
    end

    // Controller, accumulator and select rotation; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_acc   <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= '0;
                        r_sel   <= {{(WIDTH-1){1'b0}}, 1'b1};
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_sel[WIDTH-1]) begin
                        // Last multiplier bit: publish the finished product.
                        r_p     <= w_acc_next;
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_sel <= {r_sel[WIDTH-2:0], r_sel[WIDTH-1]};
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sel   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mult_seq
//  Description : Self-checking bench for shift_add_mult_seq at WIDTH=4 and
//                WIDTH=8, with a cycle-level behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_add_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4;
    logic        done4;
    logic [7:0]  p4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;
    bit model_live = 1'b0;

    always #5 clk = ~clk;

    shift_add_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .P(p4)
    );

    shift_add_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .P(p8)
    );

    // Reference model: phase 0 idle, 1..W running, W+1 done; product by '*'.
    int          m4_phase = 0;
    int unsigned m4_a = 0, m4_b = 0, m4_p = 0;
    int          m8_phase = 0;
    int unsigned m8_a = 0, m8_b = 0, m8_p = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m4_phase = 0; m4_p = 0;
            m8_phase = 0; m8_p = 0;
        end else begin
            if (m4_phase == 0) begin
                if (start4) begin m4_phase = 1; m4_a = a4; m4_b = b4; end
            end else if (m4_phase < 4) m4_phase++;
            else if (m4_phase == 4) begin m4_phase = 5; m4_p = m4_a * m4_b; end
            else m4_phase = 0;

            if (m8_phase == 0) begin
                if (start8) begin m8_phase = 1; m8_a = a8; m8_b = b8; end
            end else if (m8_phase < 8) m8_phase++;
            else if (m8_phase == 8) begin m8_phase = 9; m8_p = m8_a * m8_b; end
            else m8_phase = 0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("m4.busy", longint'(busy4), longint'(m4_phase >= 1 && m4_phase <= 4));
            chk("m4.done", longint'(done4), longint'(m4_phase == 5));
            chk("m4.P",    longint'(p4),    longint'(m4_p));
            chk("m8.busy", longint'(busy8), longint'(m8_phase >= 1 && m8_phase <= 8));
            chk("m8.done", longint'(done8), longint'(m8_phase == 9));
            chk("m8.P",    longint'(p8),    longint'(m8_p));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then wait (bounded) for done on the 4-bit DUT.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input int exp_p);
        int n;
        a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 30) begin tick(); n++; end
        chk("lat4", longint'(n), 64'd5);
        chk("P4 literal", longint'(p4), longint'(exp_p));
        tick();
    endtask

    initial begin
        int n;
        bit saw_done;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_live = 1'b1;
        chk("reset busy", longint'(busy4), 64'd0);
        chk("reset done", longint'(done4), 64'd0);
        chk("reset P",    longint'(p4),    64'd0);

        // Basic multiply, then P must hold.
        run4(4'd3, 4'd5, 15);
        repeat (10) tick();
        chk("P hold", longint'(p4), 64'd15);

        run4(4'd15, 4'd15, 225);
        run4(4'd0,  4'd9,  0);
        run4(4'd9,  4'd0,  0);

        // Second start while busy is ignored; A/B changes have no effect.
        a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
        tick();                              // now cycle 1
        start4 = 1'b0;
        tick();                              // now cycle 2
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        tick();                              // now cycle 3
        start4 = 1'b0;
        tick(); tick();                      // now cycle 5
        chk("overlap done", longint'(done4), 64'd1);
        chk("overlap P",    longint'(p4),    64'd42);
        tick();

        // Reset mid-run discards the operation.
        a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(); tick();                      // now cycle 3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst busy", longint'(busy4), 64'd0);
        chk("rst P",    longint'(p4),    64'd0);
        saw_done = 1'b0;
        repeat (8) begin
            if (done4) saw_done = 1'b1;
            tick();
        end
        chk("rst no done", longint'(saw_done), 64'd0);
        run4(4'd2, 4'd2, 4);

        // Back-to-back with start held high.
        a4 = 4'd5; b4 = 4'd4; start4 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 5 || k == 11 || k == 17) begin
                chk("b2b done", longint'(done4), 64'd1);
                chk("b2b P",    longint'(p4),    64'd20);
            end else begin
                chk("b2b idle", longint'(done4), 64'd0);
            end
        end
        start4 = 1'b0;
        repeat (8) tick();

        // 8-bit build: full-scale operands.
        a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 40) begin tick(); n++; end
        chk("lat8", longint'(n), 64'd9);
        chk("P8 literal", longint'(p8), 64'd65025);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
